// File: rtl/dcm_axis.sv
// dcm_axis: closed-loop DC motor positioning axis.
// Counts encoder pulses into a signed-wrapping position and drives a PWM
// H-bridge towards a commanded target with a duty ramp. It also handles
// braking, stall detection, over-temperature limiting and driver fault
// recovery. All outputs are registered.
module dcm_axis #(
    parameter int POS_WIDTH    = 24,
    parameter int PWM_WIDTH    = 8,
    parameter int RAMP_DIV     = 256,
    parameter int STALL_CYCLES = 100000,
    parameter int BRAKE_CYCLES = 1000,
    parameter int RESET_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    input  logic [PWM_WIDTH-1:0] cmd_speed,
    input  logic [POS_WIDTH-1:0] cmd_pos,
    input  logic                 fault_clear,
    input  logic                 motor_pulse,
    input  logic                 motor_fault,
    input  logic                 motor_otw,
    output logic                 motor_left,
    output logic                 motor_right,
    output logic                 motor_reset,
    output logic [POS_WIDTH-1:0] cur_pos,
    output logic                 busy,
    output logic                 done,
    output logic [2:0]           status
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FWD   = 3'd1;
    localparam logic [2:0] ST_REV   = 3'd2;
    localparam logic [2:0] ST_BRAKE = 3'd3;
    localparam logic [2:0] ST_FAULT = 3'd4;
    localparam logic [2:0] ST_RSTP  = 3'd5;

    localparam int SW = $clog2(STALL_CYCLES + 1);
    localparam int BW = $clog2(BRAKE_CYCLES + 1);
    localparam int RW = $clog2(RAMP_DIV + 1);
    localparam int XW = $clog2(RESET_CYCLES + 1);
    localparam logic [SW-1:0] STALL_LAST = SW'(STALL_CYCLES - 1);
    localparam logic [BW-1:0] BRAKE_LAST = BW'(BRAKE_CYCLES - 1);
    localparam logic [RW-1:0] RAMP_LAST  = RW'(RAMP_DIV - 1);
    localparam logic [XW-1:0] RESET_LAST = XW'(RESET_CYCLES - 1);

    // Direction decision: sign of (target - position) as a wrapping signed value.
    function automatic logic [2:0] dir_state(input logic [POS_WIDTH-1:0] tgt,
                                             input logic [POS_WIDTH-1:0] pos);
        logic [POS_WIDTH-1:0] d;
        d = tgt - pos;
        if (d == {POS_WIDTH{1'b0}}) begin
            dir_state = ST_BRAKE;
        end else if (d[POS_WIDTH-1]) begin
            dir_state = ST_REV;
        end else begin
            dir_state = ST_FWD;
        end
    endfunction

    logic                 p_meta_r, p_sync_r, p_prev_r, cnt_edge_s;
    logic [POS_WIDTH-1:0] cur_pos_r, cur_pos_n_s, target_r, target_n_s, tgt_eval_s;
    logic [PWM_WIDTH-1:0] speed_r, speed_n_s, duty_r, duty_n_s, lim_s, pwm_cnt_r, pwm_n_s;
    logic [2:0]           state_r, state_n_s, eval_s;
    logic                 pending_r, pending_n_s, dir_fwd_r, dir_fwd_n_s;
    logic                 fault_take_s, run_n_s;
    logic [SW-1:0]        stall_cnt_r, stall_cnt_n_s;
    logic [BW-1:0]        brake_cnt_r, brake_cnt_n_s;
    logic [RW-1:0]        ramp_cnt_r, ramp_cnt_n_s;
    logic [XW-1:0]        rst_cnt_r, rst_cnt_n_s;
    logic                 stall_r, stall_n_s, drv_fault_r, drv_fault_n_s;
    logic                 otw_seen_r, otw_seen_n_s;
    logic                 motor_left_r, motor_right_r, motor_reset_r, busy_r, done_r;

    assign cnt_edge_s   = p_sync_r & ~p_prev_r;
    assign pwm_n_s      = pwm_cnt_r + PWM_WIDTH'(1);
    assign fault_take_s = motor_fault && (state_r != ST_RSTP);
    assign tgt_eval_s   = cmd_valid ? cmd_pos : target_r;

    // Position tracking: each encoder edge moves in the last driven direction (also while coasting).
    always_comb begin
        if (cnt_edge_s) begin
            if (dir_fwd_r) begin
                cur_pos_n_s = cur_pos_r + POS_WIDTH'(1);
            end else begin
                cur_pos_n_s = cur_pos_r - POS_WIDTH'(1);
            end
        end else begin
            cur_pos_n_s = cur_pos_r;
        end
    end

    // Axis sequencer: state, target, status flags and all phase counters.
    always_comb begin
        state_n_s     = state_r;
        target_n_s    = target_r;
        speed_n_s     = speed_r;
        pending_n_s   = pending_r;
        stall_n_s     = stall_r;
        drv_fault_n_s = drv_fault_r;
        otw_seen_n_s  = otw_seen_r | motor_otw;
        eval_s        = ST_BRAKE;
        lim_s         = speed_r;
        if (fault_take_s) begin
            state_n_s     = ST_FAULT;
            drv_fault_n_s = 1'b1;
            pending_n_s   = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        target_n_s = cmd_pos;
                        speed_n_s  = cmd_speed;
                        state_n_s  = dir_state(cmd_pos, cur_pos_r);
                    end else begin
                        state_n_s = ST_IDLE;
                    end
                end
                ST_FWD, ST_REV: begin
                    if ((stall_cnt_r == STALL_LAST) && !cnt_edge_s) begin
                        state_n_s   = ST_FAULT;
                        stall_n_s   = 1'b1;
                        pending_n_s = 1'b0;
                    end else if (cmd_valid) begin
                        // New target wins over arrival; it is evaluated next cycle.
                        target_n_s  = cmd_pos;
                        speed_n_s   = cmd_speed;
                        pending_n_s = 1'b1;
                    end else if (pending_r) begin
                        eval_s = dir_state(target_r, cur_pos_r);
                        if (eval_s == state_r) begin
                            pending_n_s = 1'b0;
                        end else if (eval_s == ST_BRAKE) begin
                            pending_n_s = 1'b0;
                            state_n_s   = ST_BRAKE;
                        end else begin
                            // Reversal: brake first, keep the move pending.
                            state_n_s = ST_BRAKE;
                        end
                    end else if (cur_pos_r == target_r) begin
                        state_n_s = ST_BRAKE;
                    end else begin
                        state_n_s = state_r;
                    end
                end
                ST_BRAKE: begin
                    if (cmd_valid) begin
                        target_n_s  = cmd_pos;
                        speed_n_s   = cmd_speed;
                        pending_n_s = 1'b1;
                    end else begin
                        pending_n_s = pending_r;
                    end
                    if (brake_cnt_r == BRAKE_LAST) begin
                        if (cmd_valid || pending_r) begin
                            eval_s      = dir_state(tgt_eval_s, cur_pos_r);
                            pending_n_s = 1'b0;
                            state_n_s   = eval_s;
                        end else begin
                            state_n_s = ST_IDLE;
                        end
                    end else begin
                        state_n_s = ST_BRAKE;
                    end
                end
                ST_FAULT: begin
                    if (fault_clear) begin
                        state_n_s     = ST_RSTP;
                        stall_n_s     = 1'b0;
                        drv_fault_n_s = 1'b0;
                        otw_seen_n_s  = 1'b0;
                    end else begin
                        state_n_s = ST_FAULT;
                    end
                end
                ST_RSTP: begin
                    if (rst_cnt_r == RESET_LAST) begin
                        if (motor_fault) begin
                            state_n_s     = ST_FAULT;
                            drv_fault_n_s = 1'b1;
                        end else begin
                            state_n_s = ST_IDLE;
                        end
                    end else begin
                        state_n_s = ST_RSTP;
                    end
                end
                default: begin
                    state_n_s = ST_IDLE;
                end
            endcase
        end

        run_n_s     = (state_n_s == ST_FWD) || (state_n_s == ST_REV);
        dir_fwd_n_s = (state_n_s == ST_FWD) ? 1'b1 : ((state_n_s == ST_REV) ? 1'b0 : dir_fwd_r);

        duty_n_s      = {PWM_WIDTH{1'b0}};
        ramp_cnt_n_s  = {RW{1'b0}};
        stall_cnt_n_s = {SW{1'b0}};
        if (run_n_s && (state_n_s == state_r)) begin
            stall_cnt_n_s = cnt_edge_s ? {SW{1'b0}} : (stall_cnt_r + SW'(1));
            lim_s         = motor_otw ? (speed_n_s >> 1) : speed_n_s;
            ramp_cnt_n_s  = (ramp_cnt_r == RAMP_LAST) ? {RW{1'b0}} : (ramp_cnt_r + RW'(1));
            if (motor_otw && (duty_r > lim_s)) begin
                duty_n_s = lim_s;
            end else if (ramp_cnt_r == RAMP_LAST) begin
                if (duty_r < lim_s) begin
                    duty_n_s = duty_r + PWM_WIDTH'(1);
                end else if (duty_r > lim_s) begin
                    duty_n_s = duty_r - PWM_WIDTH'(1);
                end else begin
                    duty_n_s = duty_r;
                end
            end else begin
                duty_n_s = duty_r;
            end
        end else begin
            duty_n_s = {PWM_WIDTH{1'b0}};
        end

        if ((state_n_s == ST_BRAKE) && (state_r == ST_BRAKE) && (brake_cnt_r != BRAKE_LAST)) begin
            brake_cnt_n_s = brake_cnt_r + BW'(1);
        end else begin
            brake_cnt_n_s = {BW{1'b0}};
        end
        if ((state_n_s == ST_RSTP) && (state_r == ST_RSTP)) begin
            rst_cnt_n_s = rst_cnt_r + XW'(1);
        end else begin
            rst_cnt_n_s = {XW{1'b0}};
        end
    end

    // State registers and registered outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            p_meta_r      <= 1'b0;
            p_sync_r      <= 1'b0;
            p_prev_r      <= 1'b0;
            cur_pos_r     <= {POS_WIDTH{1'b0}};
            target_r      <= {POS_WIDTH{1'b0}};
            speed_r       <= {PWM_WIDTH{1'b0}};
            duty_r        <= {PWM_WIDTH{1'b0}};
            pwm_cnt_r     <= {PWM_WIDTH{1'b0}};
            state_r       <= ST_IDLE;
            pending_r     <= 1'b0;
            dir_fwd_r     <= 1'b0;
            stall_cnt_r   <= {SW{1'b0}};
            brake_cnt_r   <= {BW{1'b0}};
            ramp_cnt_r    <= {RW{1'b0}};
            rst_cnt_r     <= {XW{1'b0}};
            stall_r       <= 1'b0;
            drv_fault_r   <= 1'b0;
            otw_seen_r    <= 1'b0;
            motor_left_r  <= 1'b0;
            motor_right_r <= 1'b0;
            motor_reset_r <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            p_meta_r      <= motor_pulse;
            p_sync_r      <= p_meta_r;
            p_prev_r      <= p_sync_r;
            cur_pos_r     <= cur_pos_n_s;
            target_r      <= target_n_s;
            speed_r       <= speed_n_s;
            duty_r        <= duty_n_s;
            pwm_cnt_r     <= pwm_n_s;
            state_r       <= state_n_s;
            pending_r     <= pending_n_s;
            dir_fwd_r     <= dir_fwd_n_s;
            stall_cnt_r   <= stall_cnt_n_s;
            brake_cnt_r   <= brake_cnt_n_s;
            ramp_cnt_r    <= ramp_cnt_n_s;
            rst_cnt_r     <= rst_cnt_n_s;
            stall_r       <= stall_n_s;
            drv_fault_r   <= drv_fault_n_s;
            otw_seen_r    <= otw_seen_n_s;
            motor_right_r <= (state_n_s == ST_BRAKE) || ((state_n_s == ST_FWD) && (pwm_n_s < duty_n_s));
            motor_left_r  <= (state_n_s == ST_BRAKE) || ((state_n_s == ST_REV) && (pwm_n_s < duty_n_s));
            motor_reset_r <= (state_n_s == ST_RSTP);
            busy_r        <= (state_n_s != ST_IDLE);
            done_r        <= (state_n_s == ST_BRAKE) && (brake_cnt_n_s == BRAKE_LAST) && !pending_n_s;
        end
    end

    assign motor_left  = motor_left_r;
    assign motor_right = motor_right_r;
    assign motor_reset = motor_reset_r;
    assign cur_pos     = cur_pos_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign status      = {stall_r, drv_fault_r, otw_seen_r};

endmodule

// File: tb/tb_dcm_axis.sv
// tb_dcm_axis: directed self-checking bench for dcm_axis with shortened timing
// parameters (ramp 4, stall 300, brake 20, reset pulse 8 cycles).
module tb_dcm_axis;

    localparam int PW = 24;
    localparam int WW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic [WW-1:0] cmd_speed = '0;
    logic [PW-1:0] cmd_pos = '0;
    logic          fault_clear = 1'b0;
    logic          motor_pulse = 1'b0;
    logic          motor_fault = 1'b0;
    logic          motor_otw = 1'b0;
    logic          motor_left, motor_right, motor_reset, busy, done;
    logic [PW-1:0] cur_pos;
    logic [2:0]    status;

    int n_checks = 0;
    int n_fail = 0;
    int right_only, left_only, both_on, done_cnt, mreset_cnt;

    dcm_axis #(
        .POS_WIDTH(PW), .PWM_WIDTH(WW), .RAMP_DIV(4),
        .STALL_CYCLES(300), .BRAKE_CYCLES(20), .RESET_CYCLES(8)
    ) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_speed(cmd_speed),
        .cmd_pos(cmd_pos), .fault_clear(fault_clear), .motor_pulse(motor_pulse),
        .motor_fault(motor_fault), .motor_otw(motor_otw), .motor_left(motor_left),
        .motor_right(motor_right), .motor_reset(motor_reset), .cur_pos(cur_pos),
        .busy(busy), .done(done), .status(status)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (motor_right && !motor_left) right_only++;
            if (motor_left && !motor_right) left_only++;
            if (motor_left && motor_right) both_on++;
            if (done) done_cnt++;
            if (motor_reset) mreset_cnt++;
        end
    endtask

    task automatic clear_counts();
        right_only = 0; left_only = 0; both_on = 0; done_cnt = 0; mreset_cnt = 0;
    endtask

    task automatic send_cmd(input logic [PW-1:0] pos, input logic [WW-1:0] spd);
        cmd_valid = 1'b1; cmd_pos = pos; cmd_speed = spd;
        tick(1);
        cmd_valid = 1'b0;
    endtask

    // One encoder pulse every 128 cycles.
    task automatic pulses(input int n);
        for (int k = 0; k < n; k++) begin
            motor_pulse = 1'b1;
            tick(2);
            motor_pulse = 1'b0;
            tick(126);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
    endtask

    initial begin
        clear_counts();
        // Reset state
        tick(3);
        check("rst_cur_pos", cur_pos, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_drive", {motor_left, motor_right, motor_reset}, 0);
        check("rst_status", status, 0);
        reset = 1'b0;
        tick(2);

        // Forward move to 20 at speed 100
        send_cmd(24'd20, 8'd100);
        check("fwd_busy", busy, 1);
        check("fwd_duty0_right", motor_right, 0);
        pulses(4);
        clear_counts();
        pulses(2);
        check("fwd_duty100", right_only, 100);
        check("fwd_no_left", left_only + both_on, 0);
        check("fwd_pos6", cur_pos, 6);
        pulses(13);
        clear_counts();
        pulses(1);
        check("fwd_pos20", cur_pos, 20);
        check("fwd_brake_len", both_on, 20);
        check("fwd_done_once", done_cnt, 1);
        check("fwd_busy_low", busy, 0);

        // Reverse through the wrap point
        do_reset();
        clear_counts();
        send_cmd(24'hFFFFF6, 8'd50);
        check("rev_busy", busy, 1);
        pulses(1);
        check("rev_wrap", cur_pos, 32'hFFFFFF);
        pulses(8);
        check("rev_no_right", right_only + both_on, 0);
        check("rev_drive_on", (left_only > 0) ? 32'd1 : 32'd0, 1);
        clear_counts();
        pulses(1);
        check("rev_final", cur_pos, 32'hFFFFF6);
        check("rev_done", done_cnt, 1);
        check("rev_busy_low", busy, 0);

        // Retarget with reversal
        do_reset();
        send_cmd(24'd50, 8'd100);
        pulses(30);
        check("rt_pos30", cur_pos, 30);
        clear_counts();
        send_cmd(24'd10, 8'd100);
        tick(60);
        check("rt_brake_len", both_on, 20);
        check("rt_no_done", done_cnt, 0);
        check("rt_busy", busy, 1);
        clear_counts();
        pulses(20);
        check("rt_pos10", cur_pos, 10);
        check("rt_no_right", right_only, 0);
        check("rt_done", done_cnt, 1);
        check("rt_busy_low", busy, 0);

        // Stall and recovery
        do_reset();
        send_cmd(24'd5, 8'd100);
        tick(290);
        check("stall_pre_busy", busy, 1);
        check("stall_pre_status", status, 0);
        tick(20);
        check("stall_status", status, 3'b100);
        check("stall_outputs", {motor_left, motor_right}, 0);
        check("stall_busy", busy, 1);
        clear_counts();
        fault_clear = 1'b1;
        tick(1);
        fault_clear = 1'b0;
        check("clr_status", status, 0);
        check("clr_mreset", motor_reset, 1);
        tick(20);
        check("clr_mreset_len", mreset_cnt, 8);
        check("clr_idle", busy, 0);

        // Over-temperature cap then driver fault
        do_reset();
        motor_otw = 1'b1;
        send_cmd(24'd100, 8'd200);
        pulses(4);
        clear_counts();
        pulses(2);
        check("otw_duty_cap", right_only, 100);
        check("otw_status", status, 3'b001);
        motor_fault = 1'b1;
        tick(1);
        check("flt_outputs", {motor_left, motor_right}, 0);
        check("flt_status", status, 3'b011);
        motor_fault = 1'b0;
        motor_otw = 1'b0;
        fault_clear = 1'b1;
        tick(1);
        fault_clear = 1'b0;
        tick(12);
        check("flt_recovered", {busy, status}, 0);

        // Reset in the middle of a move
        do_reset();
        send_cmd(24'd50, 8'd100);
        pulses(7);
        check("mid_pos7", cur_pos, 7);
        reset = 1'b1;
        tick(1);
        check("mid_cur_pos", cur_pos, 0);
        check("mid_outputs", {motor_left, motor_right, motor_reset, busy, done}, 0);
        check("mid_status", status, 0);
        reset = 1'b0;
        tick(10);
        check("mid_stays_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
